// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: sends {~cmd,cmd,~addr,addr} LSB first as 38 kHz-modulated marks on ir_out (repeat codes with `define IR_REPEAT_EN).
// Latency: envelope and carrier rise the cycle after tx_start is accepted; a frame lasts 2566 carrier periods.
// Backpressure: tx_start is ignored while tx_busy=1; captured address/command stay frozen for the whole frame.
module ir_nec_tx #(
   parameter int CARRIER_HALF = 658,
   parameter int LEAD_MARK    = 342,
   parameter int LEAD_SPACE   = 171,
   parameter int BIT_MARK     = 21,
   parameter int ZERO_SPACE   = 21,
   parameter int ONE_SPACE    = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_addr,
   input  logic [7:0] tx_cmd,
   input  logic       tx_repeat,
   output logic       ir_out,
   output logic       ir_env,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int HALF_W  = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
   localparam int MAX_A   = (LEAD_MARK > LEAD_SPACE) ? LEAD_MARK : LEAD_SPACE;
   localparam int MAX_B   = (ONE_SPACE > ZERO_SPACE) ? ONE_SPACE : ZERO_SPACE;
   localparam int MAX_C   = (MAX_B > BIT_MARK) ? MAX_B : BIT_MARK;
   localparam int SEG_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int SEG_W   = $clog2(SEG_MAX + 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CARRIER_HALF - 1);

`ifdef IR_REPEAT_EN
   localparam int REP_PERIOD = 4104;
   localparam int REP_SPACE  = 85;
   localparam int FRAME_W    = $clog2(REP_PERIOD);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(REP_PERIOD - 1);
`endif

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEAD_MARK,
      S_LEAD_SPACE,
      S_BIT_MARK,
      S_BIT_SPACE,
      S_STOP_MARK
`ifdef IR_REPEAT_EN
      , S_REP_GAP,
      S_REP_MARK,
      S_REP_SPACE,
      S_REP_STOP
`endif
   } state_t;

   state_t            state, state_nx;
   logic [HALF_W-1:0] half_cnt, half_nx;
   logic              carrier, carrier_nx;
   logic [SEG_W-1:0]  seg_cnt, seg_nx, seg_last;
   logic [4:0]        bit_cnt, bit_nx;
   logic [31:0]       shift, shift_nx;
   logic              done_nx;
   logic              tick, seg_end, go_idle;
`ifdef IR_REPEAT_EN
   logic [FRAME_W-1:0] frame_cnt, frame_nx;
`else
   logic              unused_repeat;
   assign unused_repeat = tx_repeat;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         half_cnt  <= '0;
         carrier   <= 1'b0;
         seg_cnt   <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         tx_done   <= 1'b0;
`ifdef IR_REPEAT_EN
         frame_cnt <= '0;
`endif
      end else begin
         state     <= state_nx;
         half_cnt  <= half_nx;
         carrier   <= carrier_nx;
         seg_cnt   <= seg_nx;
         bit_cnt   <= bit_nx;
         shift     <= shift_nx;
         tx_done   <= done_nx;
`ifdef IR_REPEAT_EN
         frame_cnt <= frame_nx;
`endif
      end
   end

   always_comb begin
      state_nx   = state;
      half_nx    = half_cnt;
      carrier_nx = carrier;
      seg_nx     = seg_cnt;
      bit_nx     = bit_cnt;
      shift_nx   = shift;
      done_nx    = 1'b0;
      go_idle    = 1'b0;
      seg_last   = '0;
`ifdef IR_REPEAT_EN
      frame_nx   = frame_cnt;
`endif
      // A tick closes each carrier period, so segments always begin on a rising carrier.
      tick = (carrier == 1'b0) && (half_cnt == HALF_LAST);

      case (state)
         S_LEAD_MARK:  seg_last = SEG_W'(LEAD_MARK - 1);
         S_LEAD_SPACE: seg_last = SEG_W'(LEAD_SPACE - 1);
         S_BIT_MARK:   seg_last = SEG_W'(BIT_MARK - 1);
         S_BIT_SPACE:  seg_last = shift[0] ? SEG_W'(ONE_SPACE - 1) : SEG_W'(ZERO_SPACE - 1);
         S_STOP_MARK:  seg_last = SEG_W'(BIT_MARK - 1);
`ifdef IR_REPEAT_EN
         S_REP_MARK:   seg_last = SEG_W'(LEAD_MARK - 1);
         S_REP_SPACE:  seg_last = SEG_W'(REP_SPACE - 1);
         S_REP_STOP:   seg_last = SEG_W'(BIT_MARK - 1);
`endif
         default:      seg_last = '0;
      endcase
      seg_end = tick && (seg_cnt == seg_last);
`ifdef IR_REPEAT_EN
      // The gap is timed from the start of the previous frame or repeat, not from its end.
      if (state == S_REP_GAP) seg_end = tick && (frame_cnt == FRAME_LAST);
`endif

      if (state == S_IDLE) begin
         if (tx_start) begin
            state_nx   = S_LEAD_MARK;
            half_nx    = '0;
            carrier_nx = 1'b1;
            seg_nx     = '0;
            bit_nx     = '0;
            shift_nx   = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
`ifdef IR_REPEAT_EN
            frame_nx   = '0;
`endif
         end
      end else begin
         if (half_cnt == HALF_LAST) begin
            half_nx    = '0;
            carrier_nx = ~carrier;
         end else begin
            half_nx = half_cnt + 1'b1;
         end
`ifdef IR_REPEAT_EN
         if (tick) frame_nx = frame_cnt + 1'b1;
`endif
         if (seg_end) begin
            seg_nx = '0;
            case (state)
               S_LEAD_MARK:  state_nx = S_LEAD_SPACE;
               S_LEAD_SPACE: state_nx = S_BIT_MARK;
               S_BIT_MARK:   state_nx = S_BIT_SPACE;
               S_BIT_SPACE: begin
                  shift_nx = shift >> 1;
                  if (bit_cnt == 5'd31) begin
                     state_nx = S_STOP_MARK;
                  end else begin
                     bit_nx   = bit_cnt + 1'b1;
                     state_nx = S_BIT_MARK;
                  end
               end
`ifdef IR_REPEAT_EN
               S_STOP_MARK, S_REP_STOP: begin
                  if (tx_repeat) state_nx = S_REP_GAP;
                  else           go_idle  = 1'b1;
               end
               S_REP_GAP: begin
                  state_nx = S_REP_MARK;
                  frame_nx = '0;
               end
               S_REP_MARK:  state_nx = S_REP_SPACE;
               S_REP_SPACE: state_nx = S_REP_STOP;
`else
               S_STOP_MARK: go_idle = 1'b1;
`endif
               default:     state_nx = S_IDLE;
            endcase
         end else if (tick) begin
            seg_nx = seg_cnt + 1'b1;
         end
`ifdef IR_REPEAT_EN
         if (state == S_REP_GAP) seg_nx = '0;
`endif
         if (go_idle) begin
            state_nx   = S_IDLE;
            half_nx    = '0;
            carrier_nx = 1'b0;
            seg_nx     = '0;
            bit_nx     = '0;
            done_nx    = 1'b1;
         end
      end
   end

   always_comb begin
      ir_env = 1'b0;
      case (state)
         S_LEAD_MARK, S_BIT_MARK, S_STOP_MARK: ir_env = 1'b1;
`ifdef IR_REPEAT_EN
         S_REP_MARK, S_REP_STOP:               ir_env = 1'b1;
`endif
         default:                              ir_env = 1'b0;
      endcase
   end

   assign ir_out  = ir_env & carrier;
   assign tx_busy = (state != S_IDLE);

endmodule
